// File: rtl/msu_pkg.sv
// Shared constants and types for the MSU squaring sequencer.
// Holds the FSM state encoding, error codes and the coefficient slot geometry.
`ifndef MOD_LEN_DEF
`define MOD_LEN_DEF 1024
`endif

package msu_pkg;
  localparam int WORD_LEN = 16;
  localparam int BIT_LEN  = 17;
  localparam int SLOT_W   = 32;
  localparam int CARRY_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_NORM = 2'd3
  } msu_state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
endpackage

// File: rtl/msu_carry_norm.sv
// One step of serial carry propagation: folds a 17-bit coefficient plus the
// running carry into a 16-bit digit and the next carry.
module msu_carry_norm
  import msu_pkg::*;
(
  input  logic [SLOT_W-1:0]   slot_i,
  input  logic [CARRY_W-1:0]  carry_i,
  output logic [WORD_LEN-1:0] digit_o,
  output logic [CARRY_W-1:0]  carry_o,
  output logic                ovf_o
);
  logic [BIT_LEN:0] sum;

  // The largest sum is 0x1FFFF + 3, so two carry bits always suffice.
  always_comb begin
    sum     = {1'b0, slot_i[BIT_LEN-1:0]} + {{(BIT_LEN + 1 - CARRY_W){1'b0}}, carry_i};
    digit_o = sum[WORD_LEN-1:0];
    carry_o = sum[WORD_LEN +: CARRY_W];
    ovf_o   = |slot_i[SLOT_W-1:BIT_LEN];
  end
endmodule

// File: rtl/msu_sequencer.sv
// Drives an MSU through T repeated squarings of x0, normalizing each redundant
// response back to a MOD_LEN-bit value before issuing the next request.
module msu_sequencer #(
  parameter int MOD_LEN               = `MOD_LEN_DEF,
  parameter int WORD_LEN              = 16,
  parameter int REDUNDANT_ELEMENTS    = 2,
  parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
  parameter int NUM_ELEMENTS          = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
  parameter int SQ_OUT_BITS           = NUM_ELEMENTS * WORD_LEN * 2,
  parameter int ITER_BITS             = 64,
  parameter int TIMEOUT_CYCLES        = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [MOD_LEN-1:0]     start_value,
  input  logic [ITER_BITS-1:0]   iterations,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             error,
  output logic [MOD_LEN-1:0]     result,
  output logic [ITER_BITS-1:0]   iter_count,
  output logic                   msu_valid_in,
  output logic [MOD_LEN-1:0]     msu_sq_in,
  input  logic                   msu_valid_out,
  input  logic [SQ_OUT_BITS-1:0] msu_sq_out,
  output msu_pkg::msu_state_e    state_dbg
);
  import msu_pkg::msu_state_e;
  import msu_pkg::ST_IDLE;
  import msu_pkg::ST_SEND;
  import msu_pkg::ST_WAIT;
  import msu_pkg::ST_NORM;
  import msu_pkg::ERR_OK;
  import msu_pkg::ERR_TIMEOUT;
  import msu_pkg::ERR_OVERFLOW;
  import msu_pkg::SLOT_W;
  import msu_pkg::CARRY_W;

  localparam int NORM_W = NUM_ELEMENTS * WORD_LEN;
  localparam int IDX_W  = $clog2(NUM_ELEMENTS);
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

  // MSU handshake: msu_valid_in is a one-cycle request pulse and msu_sq_in
  // stays stable until the single-cycle msu_valid_out response; there is no
  // back-pressure, and responses seen outside WAIT are dropped.
  msu_state_e             state_q, state_d;
  logic [MOD_LEN-1:0]     value_q, value_d;
  logic [SQ_OUT_BITS-1:0] sq_q, sq_d;
  logic [NORM_W-1:0]      norm_q, norm_d;
  logic [CARRY_W-1:0]     carry_q, carry_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   ovf_q, ovf_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [ITER_BITS-1:0]   iter_count_q, iter_count_d;
  logic [ITER_BITS-1:0]   iter_target_q, iter_target_d;
  logic                   done_q, done_d;
  logic [1:0]             error_q, error_d;
  logic [MOD_LEN-1:0]     result_q, result_d;

  logic [WORD_LEN-1:0]    digit;
  logic [CARRY_W-1:0]     carry_next;
  logic                   slot_ovf;
  logic [NORM_W-1:0]      norm_shift;
  logic [ITER_BITS-1:0]   iter_next;
  logic                   ovf_end;

  msu_carry_norm u_norm (
    .slot_i  (sq_q[SLOT_W-1:0]),
    .carry_i (carry_q),
    .digit_o (digit),
    .carry_o (carry_next),
    .ovf_o   (slot_ovf)
  );

  always_comb begin
    state_d       = state_q;
    value_d       = value_q;
    sq_d          = sq_q;
    norm_d        = norm_q;
    carry_d       = carry_q;
    idx_d         = idx_q;
    ovf_d         = ovf_q;
    timer_d       = timer_q;
    iter_count_d  = iter_count_q;
    iter_target_d = iter_target_q;
    done_d        = 1'b0;
    error_d       = error_q;
    result_d      = result_q;

    // Digits enter at the top so slot j lands at bit j*WORD_LEN after the pass.
    norm_shift = {digit, norm_q[NORM_W-1:WORD_LEN]};
    iter_next  = iter_count_q + ITER_BITS'(1);
    ovf_end    = ovf_q | slot_ovf | (|norm_shift[NORM_W-1:MOD_LEN]) | (|carry_next);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d      = ERR_OK;
          iter_count_d = '0;
          timer_d      = '0;
          if (iterations == '0) begin
            done_d   = 1'b1;
            result_d = start_value;
          end else begin
            value_d       = start_value;
            iter_target_d = iterations;
            state_d       = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (msu_valid_out) begin
          sq_d    = msu_sq_out;
          idx_d   = '0;
          carry_d = '0;
          ovf_d   = 1'b0;
          state_d = ST_NORM;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          error_d = ERR_TIMEOUT;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_NORM: begin
        sq_d    = sq_q >> SLOT_W;
        norm_d  = norm_shift;
        carry_d = carry_next;
        ovf_d   = ovf_q | slot_ovf;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_ELEMENTS - 1)) begin
          if (ovf_end) begin
            error_d = ERR_OVERFLOW;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            value_d      = norm_shift[MOD_LEN-1:0];
            iter_count_d = iter_next;
            if (iter_next == iter_target_q) begin
              done_d   = 1'b1;
              result_d = norm_shift[MOD_LEN-1:0];
              state_d  = ST_IDLE;
            end else begin
              state_d = ST_SEND;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      value_q       <= '0;
      sq_q          <= '0;
      norm_q        <= '0;
      carry_q       <= '0;
      idx_q         <= '0;
      ovf_q         <= 1'b0;
      timer_q       <= '0;
      iter_count_q  <= '0;
      iter_target_q <= '0;
      done_q        <= 1'b0;
      error_q       <= ERR_OK;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      value_q       <= value_d;
      sq_q          <= sq_d;
      norm_q        <= norm_d;
      carry_q       <= carry_d;
      idx_q         <= idx_d;
      ovf_q         <= ovf_d;
      timer_q       <= timer_d;
      iter_count_q  <= iter_count_d;
      iter_target_q <= iter_target_d;
      done_q        <= done_d;
      error_q       <= error_d;
      result_q      <= result_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign error        = error_q;
  assign result       = result_q;
  assign iter_count   = iter_count_q;
  assign msu_valid_in = (state_q == ST_SEND);
  assign msu_sq_in    = value_q;
  assign state_dbg    = state_q;
endmodule
